// File: rtl/pll_lock_detect.sv
// PLL lock monitor: measures the osc period in clock cycles, checks it against div and trim stability.
// Optional build macro PLL_LOCK_HIST_EN adds a saturating unlock_count output.
module pll_lock_detect #(
  parameter int LOCK_CNT   = 8,
  parameter int UNLOCK_CNT = 2,
  parameter int TOL        = 1,
  parameter int TIMEOUT    = 63
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        osc,
  input  logic [4:0]  div,
  input  logic [25:0] trim,
  output logic        locked,
  output logic        lock_lost,
  output logic [5:0]  period
`ifdef PLL_LOCK_HIST_EN
  ,
  output logic [7:0]  unlock_count
`endif
);

  typedef enum logic [1:0] {IDLE, ACQUIRE, LOCKED} state_t;

  state_t      state_q, state_d;
  logic        s1_q, s2_q, s3_q;
  logic [5:0]  pcnt_q, pcnt_d;
  logic [5:0]  period_q, period_d;
  logic [3:0]  gcnt_q, gcnt_d;
  logic [3:0]  bcnt_q, bcnt_d;
  logic [25:0] trim_hist_q, trim_hist_d;
  logic        hist_vld_q, hist_vld_d;
  logic        locked_q, locked_d;
  logic        lost_q, lost_d;

  logic rise, timeout, sample_ev, trim_ok, good;

  function automatic logic [5:0] sat_inc6(input logic [5:0] v);
    return (v == 6'd63) ? v : v + 6'd1;
  endfunction

  function automatic logic [3:0] sat_inc4(input logic [3:0] v);
    return (v == 4'd15) ? v : v + 4'd1;
  endfunction

  // 7-bit signed difference so period - div never wraps; div of zero never matches
  function automatic logic in_tol(input logic [5:0] p, input logic [4:0] d);
    logic signed [6:0] diff;
    diff = $signed({1'b0, p}) - $signed({2'b00, d});
    if (diff < 0) diff = -diff;
    return (d != 5'd0) && (diff <= $signed(7'(TOL)));
  endfunction

  assign rise      = s2_q & ~s3_q;
  assign timeout   = ~rise && (pcnt_q >= 6'(TIMEOUT));
  assign sample_ev = rise | timeout;

  always_comb begin
    state_d     = state_q;
    pcnt_d      = sample_ev ? 6'd0 : sat_inc6(pcnt_q);
    period_d    = period_q;
    gcnt_d      = gcnt_q;
    bcnt_d      = bcnt_q;
    trim_hist_d = trim_hist_q;
    hist_vld_d  = hist_vld_q;
    locked_d    = locked_q;
    lost_d      = 1'b0;

    if (rise)
      period_d = sat_inc6(pcnt_q);
    else if (timeout)
      period_d = 6'd63;

    // First sample after IDLE has no trim history and is judged on period alone
    trim_ok = ~hist_vld_q | (trim == trim_hist_q);
    good    = rise & in_tol(period_d, div) & trim_ok;

    case (state_q)
      IDLE: begin
        if (rise) begin
          state_d    = ACQUIRE;
          gcnt_d     = 4'd0;
          bcnt_d     = 4'd0;
          hist_vld_d = 1'b0;
        end
      end
      ACQUIRE: begin
        if (sample_ev) begin
          trim_hist_d = trim;
          hist_vld_d  = 1'b1;
          if (good) begin
            gcnt_d = sat_inc4(gcnt_q);
            if (gcnt_d == 4'(LOCK_CNT)) begin
              state_d  = LOCKED;
              locked_d = 1'b1;
              bcnt_d   = 4'd0;
            end
          end else begin
            gcnt_d = 4'd0;
          end
        end
      end
      LOCKED: begin
        if (sample_ev) begin
          trim_hist_d = trim;
          hist_vld_d  = 1'b1;
          if (!good) begin
            bcnt_d = sat_inc4(bcnt_q);
            if (bcnt_d == 4'(UNLOCK_CNT)) begin
              state_d  = ACQUIRE;
              locked_d = 1'b0;
              lost_d   = 1'b1;
              gcnt_d   = 4'd0;
              bcnt_d   = 4'd0;
            end
          end else begin
            bcnt_d = 4'd0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q     <= IDLE;
      s1_q        <= 1'b0;
      s2_q        <= 1'b0;
      s3_q        <= 1'b0;
      pcnt_q      <= 6'd0;
      period_q    <= 6'd0;
      gcnt_q      <= 4'd0;
      bcnt_q      <= 4'd0;
      trim_hist_q <= 26'd0;
      hist_vld_q  <= 1'b0;
      locked_q    <= 1'b0;
      lost_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      s1_q        <= osc;
      s2_q        <= s1_q;
      s3_q        <= s2_q;
      pcnt_q      <= pcnt_d;
      period_q    <= period_d;
      gcnt_q      <= gcnt_d;
      bcnt_q      <= bcnt_d;
      trim_hist_q <= trim_hist_d;
      hist_vld_q  <= hist_vld_d;
      locked_q    <= locked_d;
      lost_q      <= lost_d;
    end
  end

`ifdef PLL_LOCK_HIST_EN
  logic [7:0] ucnt_q;

  always_ff @(posedge clock) begin
    if (!reset)
      ucnt_q <= 8'd0;
    else if (lost_d && ucnt_q != 8'd255)
      ucnt_q <= ucnt_q + 8'd1;
  end

  assign unlock_count = ucnt_q;
`endif

  assign locked    = locked_q;
  assign lock_lost = lost_q;
  assign period    = period_q;

endmodule
